// File: rtl/mmu_pkg.sv
// mmu_pkg: shared PTE layout, TLB entry, FSM states and table-entry address helper for the mmu.
package mmu_pkg;

    localparam int PTE_PRESENT   = 0;
    localparam int PTE_USER      = 1;
    localparam int PTE_NEXT_LSB  = 13;
    localparam int PTE_FRAME_LSB = 12;
    localparam int PTE_FRAME_MSB = 31;

    typedef enum logic [2:0] {
        IDLE,
        WALK1,
        WALK2,
        ACCESS,
        FAULT,
        RESP,
        DONE
    } mmu_state_t;

    typedef struct packed {
        logic        valid;
        logic [19:0] vpn;
        logic [19:0] frame;
        logic        user;
    } tlb_entry_t;

    function automatic logic [31:0] entry_addr(input logic [18:0] table_frame, input logic [9:0] index);
        return {table_frame, index, 3'b000};
    endfunction

endpackage

// File: rtl/mmu_tlb.sv
// mmu_tlb: single-entry translation cache with flush and page-table-base change invalidation.
module mmu_tlb
    import mmu_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_flush,
    input  logic [18:0] i_base_frame,
    input  logic [19:0] i_vpn,
    output logic        o_hit,
    output logic [19:0] o_frame,
    output logic        o_user,
    output logic        o_inv,
    input  logic        i_fill,
    input  logic [19:0] i_fill_vpn,
    input  logic [19:0] i_fill_frame,
    input  logic        i_fill_user
);

    tlb_entry_t  entry;
    logic [18:0] base_q;

    // An invalidating cycle also masks the hit so a same-cycle lookup never sees a stale entry.
    assign o_inv   = i_flush || (i_base_frame != base_q);
    assign o_hit   = entry.valid && !o_inv && (entry.vpn == i_vpn);
    assign o_frame = entry.frame;
    assign o_user  = entry.user;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            entry  <= '0;
            base_q <= '0;
        end else begin
            base_q <= i_base_frame;
            if (o_inv)
                entry.valid <= 1'b0;
            else if (i_fill)
                entry <= '{valid: 1'b1, vpn: i_fill_vpn, frame: i_fill_frame, user: i_fill_user};
        end
    end

endmodule

// File: rtl/mmu.sv
// mmu: CPU memory-port responder with two-level page walk, present/user checks and a one-entry TLB.
module mmu
    import mmu_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [31:0] i_cpu_address,
    input  logic        i_cpu_read,
    input  logic        i_cpu_write,
    output logic        o_cpu_valid,
    inout  wire  [63:0] io_cpu_data,
    input  logic        i_paging,
    input  logic [63:0] i_page_table_base,
    input  logic        i_is_user,
    input  logic        i_tlb_flush,
    output logic        o_error_not_present,
    output logic        o_error_not_user,
    output logic [31:0] o_phys_address,
    output logic        o_phys_read,
    output logic        o_phys_write,
    output logic [63:0] o_phys_wdata,
    input  logic [63:0] i_phys_rdata,
    input  logic        i_phys_valid
);

    mmu_state_t  state;
    mmu_state_t  next_state;
    logic [31:3] va_q;
    logic [63:0] wdata_q;
    logic [63:0] data_q;
    logic [18:0] root_q;
    logic [19:0] frame_q;
    logic        rd_q;
    logic        user_mode_q;
    logic        pte1_user_q;
    logic        got_q;
    logic        stale_q;
    logic        np_q;
    logic        nu_q;
    logic        req;
    logic        strobe;
    logic        issue;
    logic        fill;
    logic        fault_np;
    logic        fault_nu;
    logic        tlb_hit;
    logic        tlb_user;
    logic        tlb_inv;
    logic [19:0] tlb_frame;
    logic [31:0] phys_addr;
    logic        unused_bits;

    assign req                 = i_cpu_read || i_cpu_write;
    assign strobe              = o_phys_read || o_phys_write;
    assign o_cpu_valid         = (state == FAULT) || (state == RESP);
    assign o_error_not_present = (state == FAULT) && np_q;
    assign o_error_not_user    = (state == FAULT) && nu_q;
    assign io_cpu_data         = (i_cpu_read && o_cpu_valid) ? ((state == RESP) ? data_q : '0) : 'z;
    assign unused_bits         = ^{i_cpu_address[2:0], i_page_table_base[63:32], i_page_table_base[12:0]};

    mmu_tlb u_tlb (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_flush      (i_tlb_flush),
        .i_base_frame (i_page_table_base[31:13]),
        .i_vpn        (i_cpu_address[31:12]),
        .o_hit        (tlb_hit),
        .o_frame      (tlb_frame),
        .o_user       (tlb_user),
        .o_inv        (tlb_inv),
        .i_fill       (fill),
        .i_fill_vpn   (va_q[31:12]),
        .i_fill_frame (data_q[PTE_FRAME_MSB:PTE_FRAME_LSB]),
        .i_fill_user  (pte1_user_q && data_q[PTE_USER])
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            state <= IDLE;
        else
            state <= next_state;
    end

    // Walk states spend one cycle after each PTE arrives (got_q) evaluating it.
    always_comb begin
        next_state = state;
        fault_np   = 1'b0;
        fault_nu   = 1'b0;
        fill       = 1'b0;
        issue      = 1'b0;
        phys_addr  = {frame_q, va_q[11:3], 3'b000};
        case (state)
            IDLE: begin
                if (req) begin
                    fault_nu   = i_paging && tlb_hit && i_is_user && !tlb_user;
                    next_state = (!i_paging || tlb_hit) ? (fault_nu ? FAULT : ACCESS) : WALK1;
                end
            end
            WALK1, WALK2: begin
                issue     = !strobe && !got_q;
                phys_addr = (state == WALK1) ? entry_addr(root_q, va_q[31:22])
                                             : entry_addr(data_q[PTE_FRAME_MSB:PTE_NEXT_LSB], va_q[21:12]);
                fault_np  = !data_q[PTE_PRESENT];
                fault_nu  = !fault_np && user_mode_q && !(data_q[PTE_USER] && ((state == WALK1) || pte1_user_q));
                if (got_q)
                    next_state = (fault_np || fault_nu) ? FAULT : ((state == WALK1) ? WALK2 : ACCESS);
                fill = got_q && (state == WALK2) && !fault_np && !fault_nu && !stale_q;
            end
            ACCESS: begin
                issue = !strobe;
                if (strobe && i_phys_valid)
                    next_state = RESP;
            end
            FAULT, RESP: next_state = DONE;
            default:     next_state = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            va_q           <= '0;
            wdata_q        <= '0;
            data_q         <= '0;
            root_q         <= '0;
            frame_q        <= '0;
            rd_q           <= 1'b0;
            user_mode_q    <= 1'b0;
            pte1_user_q    <= 1'b0;
            got_q          <= 1'b0;
            stale_q        <= 1'b0;
            np_q           <= 1'b0;
            nu_q           <= 1'b0;
            o_phys_address <= '0;
            o_phys_read    <= 1'b0;
            o_phys_write   <= 1'b0;
            o_phys_wdata   <= '0;
        end else begin
            if (state == IDLE && req) begin
                va_q        <= i_cpu_address[31:3];
                wdata_q     <= io_cpu_data;
                rd_q        <= i_cpu_read;
                user_mode_q <= i_is_user;
                root_q      <= i_page_table_base[31:13];
                frame_q     <= i_paging ? tlb_frame : i_cpu_address[31:12];
                stale_q     <= 1'b0;
            end else begin
                // Any invalidation during a walk forbids filling from it.
                stale_q <= stale_q || tlb_inv;
            end
            if (state == WALK1 && got_q)
                pte1_user_q <= data_q[PTE_USER];
            if (state == WALK2 && got_q)
                frame_q <= data_q[PTE_FRAME_MSB:PTE_FRAME_LSB];
            got_q <= (state == WALK1 || state == WALK2) && strobe && i_phys_valid;
            if (next_state == FAULT) begin
                np_q <= fault_np;
                nu_q <= fault_nu;
            end
            if (issue) begin
                o_phys_address <= phys_addr;
                o_phys_read    <= (state != ACCESS) || rd_q;
                o_phys_write   <= (state == ACCESS) && !rd_q;
                if (state == ACCESS && !rd_q)
                    o_phys_wdata <= wdata_q;
            end else if (strobe && i_phys_valid) begin
                o_phys_read  <= 1'b0;
                o_phys_write <= 1'b0;
                if (o_phys_read)
                    data_q <= i_phys_rdata;
            end
        end
    end

endmodule
